synchronized_input_debouncer: RTL and testbench
===============================================

// Module: synchronized_input_debouncer
// PURPOSE
//  Consumes the 1-bit output of a double-flop synchronizer (off-chip button, strap or slow status
//  line already in the clk domain) and rejects glitches and bounce.
//  Emits a clean debounced level plus one-cycle rise/fall pulses for downstream control logic.
//  Sits directly downstream of the synchronizer; the synchronizer's enable and this enable are
//  normally driven by the same signal.
// PARAMETERS
//  STABLE_CYCLES  16  consecutive enabled cycles the input must differ from level_out before level_out flips; legal >= 1
//  INIT_LEVEL     0   value of level_out after reset
//  CNT_W          $clog2(STABLE_CYCLES+1)  counter width; derived, not to be overridden
// PORTS
//  clk        in   1      single clock
//  rst        in   1      reset: synchronous, active-low
//  enable     in   1      qualifies every state/counter update; low = freeze
//  in_sync    in   1      already-synchronized input; never a raw pad signal
//  level_out  out  1      debounced level
//  rise_out   out  1      1-cycle pulse when level_out goes 0->1
//  fall_out   out  1      1-cycle pulse when level_out goes 1->0
//  busy       out  1      high while a candidate transition is being qualified (states CHK_*)
// BEHAVIOUR
//  Reset (rst==0 at a clk edge), any state:
//   - level_out=INIT_LEVEL; rise_out=fall_out=busy=0; counter=0
//   - state = STABLE_HI if INIT_LEVEL else STABLE_LO
//   - Reset wins over enable and in_sync; a reset mid-qualification discards the partial count.
//  FSM states: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO (all registered).
//  All transitions below happen only on edges with enable==1. With enable==0:
//   - state, counter and level_out hold; rise_out/fall_out forced 0 that cycle.
//  STABLE_LO, in_sync==1:
//   - STABLE_CYCLES==1: go straight to STABLE_HI, level_out<=1, rise_out<=1.
//   - Otherwise: go to CHK_HI, counter<=1.
//  CHK_HI:
//   - in_sync==0: back to STABLE_LO, counter<=0; no pulse (glitch rejected).
//   - in_sync==1 and counter==STABLE_CYCLES-1: go to STABLE_HI, level_out<=1, rise_out<=1, counter<=0.
//   - in_sync==1 otherwise: counter<=counter+1.
//  STABLE_HI / CHK_LO: mirror of the above with polarities swapped; fall_out replaces rise_out.
//  Latency: level_out changes on the edge ending the STABLE_CYCLES-th consecutive enabled cycle
//   with in_sync != level_out, i.e. exactly STABLE_CYCLES enabled cycles after the first differing sample.
//  Pulse rules:
//   - rise_out/fall_out are registered, high for exactly one cycle, coincident with the level_out change.
//   - Never both high; never high while enable==0; cleared the following cycle even if enable then drops.
//  Enable gaps: disabled cycles neither count nor break a qualification run.
//  busy: 1 in CHK_HI/CHK_LO, 0 in STABLE_*.
//  Counter: never exceeds STABLE_CYCLES-1 and never wraps; the counter compare is done at CNT_W width.
// STRUCTURE
//  Shared package domain_crossing_pkg:
//   - debounce_state_t enum {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO}, 2-bit encoding
//   - DEBOUNCE_DEFAULT_CYCLES = 16
//  Sub-module: edge_pulse_generator, a registered level -> rise/fall pulse pair with enable gating.
//   - Instantiated once on the next-level signal; reusable by other CDC consumers.
//  Counter and FSM stay in this module.
// TESTING (STABLE_CYCLES=4, INIT_LEVEL=0 unless noted)
//  1. Release reset with in_sync=0, enable=1 -> level_out=0, rise/fall/busy=0 for 10 cycles.
//  2. in_sync 0->1 held -> busy=1 for 3 cycles; level_out=1 and rise_out=1 for one cycle on the
//     4th edge after the first sample; fall_out stays 0.
//  3. in_sync pattern 1,1,1,0,1,1,1,1 from STABLE_LO -> level_out flips only after the final four 1s
//     (8th edge); exactly one rise_out.
//  4. in_sync=1 with enable toggling 1,0,1,0,1,0,1 -> level_out flips on the 4th enabled edge (7th edge);
//     rise_out never asserted in a disabled cycle.
//  5. rst=0 asserted during CHK_HI with counter=2 -> next edge level_out=0, busy=0, counter=0;
//     requalification after release takes a full 4 cycles.
//  6. STABLE_CYCLES=1, INIT_LEVEL=1, in_sync=0 -> level_out=0 and fall_out=1 on the first enabled edge;
//     busy never asserted.

Source files
------------

// File: rtl/synchronized_input_debouncer_pkg.sv
// Shared types and defaults for the clock-domain-crossing consumers.
package domain_crossing_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } debounce_state_t;

    localparam int unsigned DEBOUNCE_DEFAULT_CYCLES = 16;

endpackage

// File: rtl/synchronized_input_debouncer_edge_pulse_generator.sv
// Registers a level and emits one-cycle rise/fall pulses on its transitions.
// Pulses are suppressed (and the level held) while enable is low.
module edge_pulse_generator #(
    parameter logic INIT_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic level_in,
    output logic level_out,
    output logic rise_out,
    output logic fall_out
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            level_out <= INIT_LEVEL;
            rise_out  <= 1'b0;
            fall_out  <= 1'b0;
        end else if (enable) begin
            level_out <= level_in;
            rise_out  <= level_in & ~level_out;
            fall_out  <= ~level_in & level_out;
        end else begin
            rise_out  <= 1'b0;
            fall_out  <= 1'b0;
        end
    end

endmodule

// File: rtl/synchronized_input_debouncer.sv
// Debounces an already-synchronized 1-bit input: the level flips only after
// STABLE_CYCLES consecutive enabled cycles of disagreement.
module synchronized_input_debouncer
    import domain_crossing_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEBOUNCE_DEFAULT_CYCLES,
    parameter logic        INIT_LEVEL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic in_sync,
    output logic level_out,
    output logic rise_out,
    output logic fall_out,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam debounce_state_t INIT_STATE = INIT_LEVEL ? STABLE_HI : STABLE_LO;

    debounce_state_t  state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (enable) begin
            unique case (state)
                STABLE_LO: begin
                    if (in_sync) begin
                        if (STABLE_CYCLES == 1) begin
                            state_nxt = STABLE_HI;
                        end else begin
                            state_nxt = CHK_HI;
                            cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                CHK_HI: begin
                    if (!in_sync) begin
                        state_nxt = STABLE_LO;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = STABLE_HI;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt   = cnt + 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!in_sync) begin
                        if (STABLE_CYCLES == 1) begin
                            state_nxt = STABLE_LO;
                        end else begin
                            state_nxt = CHK_LO;
                            cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                CHK_LO: begin
                    if (in_sync) begin
                        state_nxt = STABLE_HI;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = STABLE_LO;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt   = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = INIT_STATE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // The debounced level is implied by the state: high in STABLE_HI and while
    // qualifying a fall (CHK_LO), so the pulse stage sees the flip on the same edge.
    assign level_nxt = (state_nxt == STABLE_HI) || (state_nxt == CHK_LO);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= INIT_STATE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= (state_nxt == CHK_HI) || (state_nxt == CHK_LO);
        end
    end

    edge_pulse_generator #(
        .INIT_LEVEL (INIT_LEVEL)
    ) u_edge_pulse (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .level_in  (level_nxt),
        .level_out (level_out),
        .rise_out  (rise_out),
        .fall_out  (fall_out)
    );

endmodule

// File: tb/tb_synchronized_input_debouncer.sv
// Directed bench: vector table for STABLE_CYCLES=4/INIT_LEVEL=0, plus a
// hand-written sequence for STABLE_CYCLES=1/INIT_LEVEL=1.
module tb_synchronized_input_debouncer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, enable, in_sync;
    logic level_out, rise_out, fall_out, busy;
    logic rst1, enable1, in_sync1;
    logic level1, rise1, fall1, busy1;

    int checks = 0;
    int errors = 0;

    synchronized_input_debouncer #(
        .STABLE_CYCLES (4),
        .INIT_LEVEL    (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_sync   (in_sync),
        .level_out (level_out),
        .rise_out  (rise_out),
        .fall_out  (fall_out),
        .busy      (busy)
    );

    synchronized_input_debouncer #(
        .STABLE_CYCLES (1),
        .INIT_LEVEL    (1'b1)
    ) dut1 (
        .clk       (clk),
        .rst       (rst1),
        .enable    (enable1),
        .in_sync   (in_sync1),
        .level_out (level1),
        .rise_out  (rise1),
        .fall_out  (fall1),
        .busy      (busy1)
    );

    typedef struct {
        logic rst;
        logic enable;
        logic in_sync;
        logic level;
        logic rise;
        logic fall;
        logic busy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic e, input logic i,
                                input logic l, input logic rs, input logic f,
                                input logic b);
        vec_t v;
        v.rst = r; v.enable = e; v.in_sync = i;
        v.level = l; v.rise = rs; v.fall = f; v.busy = b;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 after the rising edge.
    task automatic step4(input logic r, input logic e, input logic i);
        @(negedge clk);
        rst = r; enable = e; in_sync = i;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic r, input logic e, input logic i);
        @(negedge clk);
        rst1 = r; enable1 = e; in_sync1 = i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; enable = 1'b1; in_sync = 1'b0;
        rst1 = 1'b0; enable1 = 1'b0; in_sync1 = 1'b1;

        //   rst en in | lvl rise fall busy
        // reset state
        add(0, 1, 0,   0, 0, 0, 0);
        add(0, 1, 1,   0, 0, 0, 0);
        // 1: idle low for 10 cycles
        for (int k = 0; k < 10; k++) add(1, 1, 0,   0, 0, 0, 0);
        // 2: held high -> busy x3, flip on 4th edge
        add(1, 1, 1,   0, 0, 0, 1);
        add(1, 1, 1,   0, 0, 0, 1);
        add(1, 1, 1,   0, 0, 0, 1);
        add(1, 1, 1,   1, 1, 0, 0);
        add(1, 1, 1,   1, 0, 0, 0);
        // back low: mirror qualification
        add(1, 1, 0,   1, 0, 0, 1);
        add(1, 1, 0,   1, 0, 0, 1);
        add(1, 1, 0,   1, 0, 0, 1);
        add(1, 1, 0,   0, 0, 1, 0);
        add(1, 1, 0,   0, 0, 0, 0);
        // 3: glitch 1,1,1,0 then 1,1,1,1
        add(1, 1, 1,   0, 0, 0, 1);
        add(1, 1, 1,   0, 0, 0, 1);
        add(1, 1, 1,   0, 0, 0, 1);
        add(1, 1, 0,   0, 0, 0, 0);
        add(1, 1, 1,   0, 0, 0, 1);
        add(1, 1, 1,   0, 0, 0, 1);
        add(1, 1, 1,   0, 0, 0, 1);
        add(1, 1, 1,   1, 1, 0, 0);
        // back low
        add(1, 1, 0,   1, 0, 0, 1);
        add(1, 1, 0,   1, 0, 0, 1);
        add(1, 1, 0,   1, 0, 0, 1);
        add(1, 1, 0,   0, 0, 1, 0);
        // 4: enable toggling 1,0,1,0,1,0,1, then pulse clears with enable low
        add(1, 1, 1,   0, 0, 0, 1);
        add(1, 0, 1,   0, 0, 0, 1);
        add(1, 1, 1,   0, 0, 0, 1);
        add(1, 0, 1,   0, 0, 0, 1);
        add(1, 1, 1,   0, 0, 0, 1);
        add(1, 0, 1,   0, 0, 0, 1);
        add(1, 1, 1,   1, 1, 0, 0);
        add(1, 0, 1,   1, 0, 0, 0);
        // back low, then 5: reset during CHK_HI at count 2
        add(1, 1, 0,   1, 0, 0, 1);
        add(1, 1, 0,   1, 0, 0, 1);
        add(1, 1, 0,   1, 0, 0, 1);
        add(1, 1, 0,   0, 0, 1, 0);
        add(1, 1, 1,   0, 0, 0, 1);
        add(1, 1, 1,   0, 0, 0, 1);
        add(0, 1, 1,   0, 0, 0, 0);
        add(1, 1, 1,   0, 0, 0, 1);
        add(1, 1, 1,   0, 0, 0, 1);
        add(1, 1, 1,   0, 0, 0, 1);
        add(1, 1, 1,   1, 1, 0, 0);
        // CHK_LO glitch rejected: no fall
        add(1, 1, 0,   1, 0, 0, 1);
        add(1, 1, 0,   1, 0, 0, 1);
        add(1, 1, 1,   1, 0, 0, 0);
        add(1, 1, 1,   1, 0, 0, 0);
        // reset from STABLE_HI returns to INIT_LEVEL without a pulse
        add(0, 1, 1,   0, 0, 0, 0);
        add(1, 1, 0,   0, 0, 0, 0);

        foreach (vecs[n]) begin
            step4(vecs[n].rst, vecs[n].enable, vecs[n].in_sync);
            check("level_out", n, level_out, vecs[n].level);
            check("rise_out",  n, rise_out,  vecs[n].rise);
            check("fall_out",  n, fall_out,  vecs[n].fall);
            check("busy",      n, busy,      vecs[n].busy);
            checks++;
            if (rise_out && fall_out) begin
                errors++;
                $display("FAIL both_pulses step %0d: got rise=1 fall=1 expected at most one", n);
            end
        end

        // 6: STABLE_CYCLES=1, INIT_LEVEL=1
        step1(0, 0, 0);
        check("s1_reset_level", 0, level1, 1'b1);
        check("s1_reset_fall",  0, fall1,  1'b0);
        check("s1_reset_busy",  0, busy1,  1'b0);
        step1(1, 0, 0);
        check("s1_disabled_level", 1, level1, 1'b1);
        check("s1_disabled_fall",  1, fall1,  1'b0);
        step1(1, 1, 0);
        check("s1_first_level", 2, level1, 1'b0);
        check("s1_first_fall",  2, fall1,  1'b1);
        check("s1_first_rise",  2, rise1,  1'b0);
        check("s1_first_busy",  2, busy1,  1'b0);
        step1(1, 1, 0);
        check("s1_hold_level", 3, level1, 1'b0);
        check("s1_hold_fall",  3, fall1,  1'b0);
        check("s1_hold_busy",  3, busy1,  1'b0);
        step1(1, 1, 1);
        check("s1_rise_level", 4, level1, 1'b1);
        check("s1_rise_rise",  4, rise1,  1'b1);
        check("s1_rise_busy",  4, busy1,  1'b0);
        step1(1, 0, 0);
        check("s1_gap_level", 5, level1, 1'b1);
        check("s1_gap_rise",  5, rise1,  1'b0);
        check("s1_gap_fall",  5, fall1,  1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
